// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I core.
// Owns PC, IR, ALU-output and memory-data holding registers and walks each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared
// variable-latency req/ready memory port. Illegal opcodes, memory timeouts and
// misaligned fetches park the FSM in a sticky FAULT state.
module rv_multicycle_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            branch_taken,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] alu_out_q,
  output logic [XLEN-1:0] mdr,
  output logic            reg_write,
  output logic [1:0]      wb_sel,
  output logic            retire,
  output logic [2:0]      state,
  output logic [1:0]      fault_cause
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_FAULT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILLEGAL
  } class_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] mdr_q;
  logic [1:0]      cause_q;
  logic [31:0]     wait_q;
  logic            busy_q;   // a fetch request is outstanding; halt no longer applies

  class_t          cls;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_target;
  logic [31:0]     wait_inc;
  logic            timeout_hit;
  logic            fetch_aligned;
  logic            fetch_req;

  // Write-back mux select for each instruction class.
  function automatic logic [1:0] wb_sel_of(input class_t c);
    case (c)
      C_LUI:                   return 2'd0;
      C_AUIPC, C_OP, C_OPIMM:  return 2'd1;
      C_JAL, C_JALR:           return 2'd2;
      C_LOAD:                  return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

  // Instruction class from the opcode field of the held IR.
  always_comb begin
    cls = C_ILLEGAL;
    case (ir_q[6:0])
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b1100011: cls = C_BRANCH;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b0010011: cls = C_OPIMM;
      7'b0110011: cls = C_OP;
      default:    cls = C_ILLEGAL;
    endcase
  end

  // PC arithmetic wraps modulo 2^XLEN; the wait counter saturates so an
  // unbounded wait (MAX_WAIT == 0) never rolls over into a false match.
  always_comb begin
    pc_plus4      = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    jalr_target   = {alu_out_q[XLEN-1:1], 1'b0};
    wait_inc      = (&wait_q) ? wait_q : wait_q + 32'd1;
    timeout_hit   = (MAX_WAIT != 0) && (wait_inc == MAX_WAIT);
    fetch_aligned = (pc_q[1:0] == 2'b00);
    fetch_req     = fetch_aligned && (busy_q || !halt);
  end

  // Sequencer FSM and the holding registers it loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= IR_NOP;
      alu_out_q <= '0;
      mdr_q     <= '0;
      cause_q   <= CAUSE_NONE;
      wait_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!fetch_aligned) begin
            state_q <= S_FAULT;
            cause_q <= CAUSE_MISALIGN;
          end else if (fetch_req) begin
            if (mem_ready) begin
              ir_q    <= mem_rdata[31:0];
              busy_q  <= 1'b0;
              state_q <= S_DECODE;
            end else if (timeout_hit) begin
              busy_q  <= 1'b0;
              state_q <= S_FAULT;
              cause_q <= CAUSE_TIMEOUT;
            end else begin
              busy_q  <= 1'b1;
              wait_q  <= wait_inc;
            end
          end
        end
        S_DECODE: begin
          if (cls == C_ILLEGAL) begin
            state_q <= S_FAULT;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_out_q <= alu_result;
          if (cls == C_LOAD || cls == C_STORE) begin
            wait_q  <= '0;
            state_q <= S_MEM;
          end else if (cls == C_BRANCH) begin
            pc_q    <= branch_taken ? alu_result : pc_plus4;
            wait_q  <= '0;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls == C_STORE) begin
              pc_q    <= pc_plus4;
              wait_q  <= '0;
              state_q <= S_FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= S_WB;
            end
          end else if (timeout_hit) begin
            state_q <= S_FAULT;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_q  <= wait_inc;
          end
        end
        S_WB: begin
          if (cls == C_JAL)       pc_q <= alu_out_q;
          else if (cls == C_JALR) pc_q <= jalr_target;
          else                    pc_q <= pc_plus4;
          wait_q  <= '0;
          state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_FAULT;
        end
      endcase
    end
  end

  // Memory port and write-back controls, all held low while reset is asserted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = rs2_data;
    reg_write = 1'b0;
    retire    = 1'b0;
    wb_sel    = 2'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = fetch_req;
        end
        S_EXECUTE: begin
          retire = (cls == C_BRANCH);
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_addr = alu_out_q;
          mem_we   = (cls == C_STORE);
          retire   = (cls == C_STORE) && mem_ready;
        end
        S_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          wb_sel    = wb_sel_of(cls);
        end
        default: ;
      endcase
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign mdr         = mdr_q;
  assign state       = state_q;
  assign fault_cause = cause_q;

endmodule
